// File: rtl/cdce62002_spi_config.sv
// cdce62002_spi_config
// Power-up SPI configuration sequencer for a CDCE62002 PLL. On start it writes
// registers 0 and 1 and, when VERIFY is set, reads both back and compares
// bits [31:4] against the written words. All SPI pins are driven from flops.
//
// Handshake: start is a single-cycle request sampled on the rising sysclk
// edge. It is accepted only when the FSM is in IDLE and at least one clock has
// passed since reset release. A start that arrives while busy is dropped
// without side effects. done/verify_ok/error are sticky until the next accepted
// start, which clears them on the same edge that raises busy.
`timescale 1ns/1ps

module cdce62002_spi_config #(
    parameter int          CLK_DIV   = 2,
    parameter int          CS_GAP    = 4,
    parameter logic [31:0] REG0_WORD = 32'h0000_0000,
    parameter logic [31:0] REG1_WORD = 32'h0000_0001,
    parameter logic [31:0] RD_CMD0   = 32'h0000_000E,
    parameter logic [31:0] RD_CMD1   = 32'h0000_001E,
    parameter int          VERIFY    = 1
) (
    input  logic       sysclk,
    input  logic       reset_INV,
    input  logic       start,
    input  logic       pll_spi_miso,
    output logic       pll_spi_clk,
    output logic       pll_spi_mosi,
    output logic       pll_spi_cs_INV,
    output logic       busy,
    output logic       done,
    output logic       verify_ok,
    output logic       error,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        CS_HOLD  = 3'd4,
        GAP      = 3'd5,
        FINISH   = 3'd6
    } state_t;

    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0]  GAP_LAST   = 8'(CS_GAP - 1);
    localparam logic [2:0]  LAST_FRAME = (VERIFY != 0) ? 3'd5 : 3'd1;
    // Low nibble of a readback is the address field and is not compared.
    localparam logic [31:0] CMP_MASK   = 32'hFFFF_FFF0;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [2:0]  frame_idx;
    logic [31:0] tx_shift;
    logic [31:0] rx_shift;
    logic        mismatch;
    logic        armed;

    logic        accept;
    logic        load_frame;
    logic        rise;
    logic        fall;
    logic        bit_step;
    logic        end_frame;
    logic        finish;

    logic        div_last;
    logic        gap_last;
    logic        bit_last;
    logic        frame_last;
    logic        read_frame;
    logic [2:0]  load_idx;
    logic [31:0] load_word;
    logic [31:0] read_expect;

    // Frame sequence: writes, then read command / readback pairs.
    // Readback frames transmit all zeros.
    function automatic logic [31:0] frame_word(input logic [2:0] idx);
        case (idx)
            3'd0:    frame_word = REG0_WORD;
            3'd1:    frame_word = REG1_WORD;
            3'd2:    frame_word = RD_CMD0;
            3'd4:    frame_word = RD_CMD1;
            default: frame_word = 32'h0000_0000;
        endcase
    endfunction

    assign div_last    = (div_cnt == DIV_LAST);
    assign gap_last    = (div_cnt == GAP_LAST);
    assign bit_last    = (bit_cnt == 5'd31);
    assign frame_last  = (frame_idx == LAST_FRAME);
    assign read_frame  = (frame_idx == 3'd3) || (frame_idx == 3'd5);
    assign read_expect = (frame_idx == 3'd3) ? REG0_WORD : REG1_WORD;
    // On the accept edge frame_idx still holds the previous run's value.
    assign load_idx    = accept ? 3'd0 : frame_idx;
    assign load_word   = frame_word(load_idx);
    assign fsm_state   = state;

    // Next-state logic and the single-cycle strobes that steer the datapath.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        load_frame = 1'b0;
        rise       = 1'b0;
        fall       = 1'b0;
        bit_step   = 1'b0;
        end_frame  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && armed) begin
                    state_nxt  = CS_SETUP;
                    accept     = 1'b1;
                    load_frame = 1'b1;
                end
            end
            CS_SETUP: begin
                if (div_last) begin
                    state_nxt = SHIFT_HI;
                    rise      = 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    state_nxt = SHIFT_LO;
                    fall      = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (div_last) begin
                    if (bit_last) begin
                        state_nxt = CS_HOLD;
                    end else begin
                        state_nxt = SHIFT_HI;
                        rise      = 1'b1;
                        bit_step  = 1'b1;
                    end
                end
            end
            CS_HOLD: begin
                if (div_last) begin
                    end_frame = 1'b1;
                    // The last frame ends the sequence directly; the
                    // inter-frame gap only separates frames.
                    state_nxt = frame_last ? FINISH : GAP;
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_nxt  = CS_SETUP;
                    load_frame = 1'b1;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
                finish    = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Blocks start on the first edge after reset release.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Divider: restarts on every state change, so it stops at its terminal value.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            div_cnt <= 8'd0;
        end else if ((state_nxt != state) || (state == IDLE) || (state == FINISH)) begin
            div_cnt <= 8'd0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Bit counter: advances at the start of each bit period after the first.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            bit_cnt <= 5'd0;
        end else if (load_frame) begin
            bit_cnt <= 5'd0;
        end else if (bit_step) begin
            bit_cnt <= bit_cnt + 5'd1;
        end
    end

    // Frame index: reset on acceptance, advanced at each frame end.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            frame_idx <= 3'd0;
        end else if (accept) begin
            frame_idx <= 3'd0;
        end else if (end_frame && !frame_last) begin
            frame_idx <= frame_idx + 3'd1;
        end
    end

    // Transmit path: rotate right, presenting the next bit on each falling clk.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            tx_shift     <= 32'h0000_0000;
            pll_spi_mosi <= 1'b0;
        end else if (load_frame) begin
            tx_shift     <= load_word;
            pll_spi_mosi <= load_word[0];
        end else if (fall) begin
            tx_shift     <= {tx_shift[0], tx_shift[31:1]};
            pll_spi_mosi <= bit_last ? 1'b0 : tx_shift[1];
        end else if (end_frame) begin
            pll_spi_mosi <= 1'b0;
        end
    end

    // SPI clock: high only between a rise strobe and the following fall strobe.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            pll_spi_clk <= 1'b0;
        end else if (rise) begin
            pll_spi_clk <= 1'b1;
        end else if (fall) begin
            pll_spi_clk <= 1'b0;
        end
    end

    // Chip select: low from frame load through the end of CS_HOLD.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            pll_spi_cs_INV <= 1'b1;
        end else if (load_frame) begin
            pll_spi_cs_INV <= 1'b0;
        end else if (end_frame) begin
            pll_spi_cs_INV <= 1'b1;
        end
    end

    // Receive path: capture miso LSB first on the edge that raises the SPI clock.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            rx_shift <= 32'h0000_0000;
        end else if (load_frame) begin
            rx_shift <= 32'h0000_0000;
        end else if (rise) begin
            rx_shift <= {pll_spi_miso, rx_shift[31:1]};
        end
    end

    // Status flags and readback comparison.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            verify_ok <= 1'b0;
            error     <= 1'b0;
            mismatch  <= 1'b0;
        end else if (accept) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            verify_ok <= 1'b0;
            error     <= 1'b0;
            mismatch  <= 1'b0;
        end else if (finish) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            verify_ok <= ~mismatch;
            error     <= mismatch;
        end else if (end_frame && read_frame &&
                     (((rx_shift ^ read_expect) & CMP_MASK) != 32'h0000_0000)) begin
            mismatch  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdce62002_spi_config.sv
// tb_cdce62002_spi_config
// Two instances: A writes only (VERIFY=0), B writes and reads back through a
// PLL model that echoes the written words, optionally with bits flipped.
`timescale 1ns/1ps

module tb_cdce62002_spi_config;

    // ---------------- clock / reset ----------------
    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic       reset_INV;
    logic       start_a, start_b;
    logic       miso_a, miso_b;
    logic       clk_a, mosi_a, cs_a, busy_a, done_a, vok_a, err_a;
    logic       clk_b, mosi_b, cs_b, busy_b, done_b, vok_b, err_b;
    logic [2:0] st_a, st_b;

    cdce62002_spi_config #(
        .CLK_DIV(2), .CS_GAP(4), .REG0_WORD(32'hA5A5_0F00), .REG1_WORD(32'h1234_5671),
        .RD_CMD0(32'h0000_000E), .RD_CMD1(32'h0000_001E), .VERIFY(0)
    ) dut_a (
        .sysclk(sysclk), .reset_INV(reset_INV), .start(start_a), .pll_spi_miso(miso_a),
        .pll_spi_clk(clk_a), .pll_spi_mosi(mosi_a), .pll_spi_cs_INV(cs_a), .busy(busy_a),
        .done(done_a), .verify_ok(vok_a), .error(err_a), .fsm_state(st_a)
    );

    cdce62002_spi_config #(
        .CLK_DIV(2), .CS_GAP(4), .REG0_WORD(32'hA5A5_0F00), .REG1_WORD(32'h1234_5671),
        .RD_CMD0(32'h0000_000E), .RD_CMD1(32'h0000_001E), .VERIFY(1)
    ) dut_b (
        .sysclk(sysclk), .reset_INV(reset_INV), .start(start_b), .pll_spi_miso(miso_b),
        .pll_spi_clk(clk_b), .pll_spi_mosi(mosi_b), .pll_spi_cs_INV(cs_b), .busy(busy_b),
        .done(done_b), .verify_ok(vok_b), .error(err_b), .fsm_state(st_b)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic        mon_clr  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- bus monitors (sampled on falling sysclk) ----------------
    int          low_a, bits_a, gap_a, busy_cnt_a;
    logic [31:0] word_a;
    logic        pclk_a, pcs_a;
    logic [31:0] fw_a[$];
    int          fl_a[$], fb_a[$], fg_a[$];

    always @(negedge sysclk) begin
        if (!reset_INV || mon_clr) begin
            low_a = 0; bits_a = 0; gap_a = 0; busy_cnt_a = 0; word_a = '0;
            fw_a.delete(); fl_a.delete(); fb_a.delete(); fg_a.delete();
        end else begin
            if (busy_a) busy_cnt_a++;
            if (!cs_a) begin
                low_a++;
                if (clk_a && !pclk_a) begin
                    word_a = {mosi_a, word_a[31:1]};
                    bits_a++;
                end
            end
            if (cs_a && !pcs_a) begin
                fw_a.push_back(word_a); fl_a.push_back(low_a); fb_a.push_back(bits_a);
                low_a = 0; bits_a = 0; word_a = '0;
            end
            if (!cs_a && pcs_a && gap_a > 0) fg_a.push_back(gap_a);
            if (!cs_a || !busy_a) gap_a = 0;
            else gap_a++;
        end
        pclk_a = clk_a;
        pcs_a  = cs_a;
    end

    int          low_b, bits_b, gap_b, busy_cnt_b;
    logic [31:0] word_b;
    logic        pclk_b, pcs_b;
    logic [31:0] fw_b[$];
    int          fl_b[$], fb_b[$], fg_b[$];

    always @(negedge sysclk) begin
        if (!reset_INV || mon_clr) begin
            low_b = 0; bits_b = 0; gap_b = 0; busy_cnt_b = 0; word_b = '0;
            fw_b.delete(); fl_b.delete(); fb_b.delete(); fg_b.delete();
        end else begin
            if (busy_b) busy_cnt_b++;
            if (!cs_b) begin
                low_b++;
                if (clk_b && !pclk_b) begin
                    word_b = {mosi_b, word_b[31:1]};
                    bits_b++;
                end
            end
            if (cs_b && !pcs_b) begin
                fw_b.push_back(word_b); fl_b.push_back(low_b); fb_b.push_back(bits_b);
                low_b = 0; bits_b = 0; word_b = '0;
            end
            if (!cs_b && pcs_b && gap_b > 0) fg_b.push_back(gap_b);
            if (!cs_b || !busy_b) gap_b = 0;
            else gap_b++;
        end
        pclk_b = clk_b;
        pcs_b  = cs_b;
    end

    // ---------------- PLL model for B ----------------
    // Frames 3 and 5 return the words captured from write frames 0 and 1,
    // XORed with flip0/flip1. Data changes on the falling SPI clock.
    logic [31:0] mdl_sh = '0;
    logic [31:0] flip0, flip1;

    always @(negedge cs_b) begin
        if (fw_b.size() == 3)      mdl_sh = fw_b[0] ^ flip0;
        else if (fw_b.size() == 5) mdl_sh = fw_b[1] ^ flip1;
        else                       mdl_sh = '0;
        miso_b = mdl_sh[0];
    end

    always @(negedge clk_b) begin
        mdl_sh = mdl_sh >> 1;
        miso_b = mdl_sh[0];
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge sysclk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start(input int which);
        @(negedge sysclk);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge sysclk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        int n = 0;
        while (n < budget && !((which == 0) ? done_a : done_b)) begin
            @(negedge sysclk);
            n++;
        end
        check_eq("done_within_budget", (which == 0) ? done_a : done_b, 1);
    endtask

    task automatic check_frames_b(input string tag);
        check_eq({tag, "_nframes"}, fw_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < fw_b.size(); i++) begin
            check_eq({tag, "_word"}, fw_b[i], exp_q[i]);
            check_eq({tag, "_low"}, fl_b[i], 132);
            check_eq({tag, "_bits"}, fb_b[i], 32);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_INV = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        miso_a = 1'b0; miso_b = 1'b0;
        flip0 = '0; flip1 = '0;
        repeat (3) @(negedge sysclk);

        // Reset values
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_vok", vok_a, 0);
        check_eq("rst_err", err_a, 0);
        check_eq("rst_cs", cs_a, 1);
        check_eq("rst_clk", clk_a, 0);
        check_eq("rst_mosi", mosi_a, 0);
        check_eq("rst_state", st_a, 0);
        check_eq("rst_cs_b", cs_b, 1);

        // start coincident with reset release is ignored
        reset_INV = 1'b1;
        start_a = 1'b1;
        @(negedge sysclk);
        start_a = 1'b0;
        repeat (3) @(negedge sysclk);
        check_eq("start_at_release_busy", busy_a, 0);
        check_eq("start_at_release_cs", cs_a, 1);

        // A: write-only sequence
        clear_mon();
        pulse_start(0);
        wait_done(0, 2000);
        @(negedge sysclk);
        check_eq("a_nframes", fw_a.size(), 2);
        if (fw_a.size() == 2) begin
            check_eq("a_word0", fw_a[0], 32'hA5A5_0F00);
            check_eq("a_word1", fw_a[1], 32'h1234_5671);
            check_eq("a_low0", fl_a[0], 132);
            check_eq("a_bits0", fb_a[0], 32);
            check_eq("a_low1", fl_a[1], 132);
        end
        check_eq("a_ngaps", fg_a.size(), 1);
        if (fg_a.size() == 1) check_eq("a_gap", fg_a[0], 4);
        check_eq("a_busy_cycles", busy_cnt_a, 2 * 132 + 4 + 1);
        check_eq("a_done", done_a, 1);
        check_eq("a_vok", vok_a, 1);
        check_eq("a_err", err_a, 0);
        check_eq("a_busy_low", busy_a, 0);

        // B: echo readback, plus an ignored start at bit 5 of frame 0
        exp_q = '{32'hA5A5_0F00, 32'h1234_5671, 32'h0000_000E, 32'h0, 32'h0000_001E, 32'h0};
        clear_mon();
        pulse_start(1);
        for (int n = 0; n < 500 && bits_b < 6; n++) @(negedge sysclk);
        pulse_start(1);
        check_eq("b_busy_mid", busy_b, 1);
        wait_done(1, 2000);
        @(negedge sysclk);
        check_frames_b("b_echo");
        check_eq("b_ngaps", fg_b.size(), 5);
        for (int i = 0; i < fg_b.size(); i++) check_eq("b_gap", fg_b[i], 4);
        check_eq("b_busy_cycles", busy_cnt_b, 6 * 132 + 5 * 4 + 1);
        check_eq("b_echo_vok", vok_b, 1);
        check_eq("b_echo_err", err_b, 0);

        // B: register 1 bit 20 flipped on readback
        flip1 = 32'h0010_0000;
        clear_mon();
        pulse_start(1);
        wait_done(1, 2000);
        check_eq("b_flip20_err", err_b, 1);
        check_eq("b_flip20_vok", vok_b, 0);

        // B: only address nibbles differ; done clears on acceptance
        flip0 = 32'h0000_000F;
        flip1 = 32'h0000_000A;
        clear_mon();
        pulse_start(1);
        check_eq("b_done_clear", done_b, 0);
        check_eq("b_err_clear", err_b, 0);
        check_eq("b_busy_accept", busy_b, 1);
        wait_done(1, 2000);
        check_eq("b_nibble_vok", vok_b, 1);
        check_eq("b_nibble_err", err_b, 0);

        // B: reset during bit 10 of frame 1, then a full rerun
        flip0 = '0;
        flip1 = '0;
        clear_mon();
        pulse_start(1);
        for (int n = 0; n < 2000 && !(fw_b.size() == 1 && bits_b == 11); n++) @(negedge sysclk);
        check_eq("b_reached_frame1_bit10", bits_b, 11);
        #2 reset_INV = 1'b0;
        #1;
        check_eq("rst_mid_cs", cs_b, 1);
        check_eq("rst_mid_clk", clk_b, 0);
        check_eq("rst_mid_busy", busy_b, 0);
        check_eq("rst_mid_state", st_b, 0);
        @(negedge sysclk);
        reset_INV = 1'b1;
        repeat (6) @(negedge sysclk);
        check_eq("no_resume_busy", busy_b, 0);
        check_eq("no_resume_cs", cs_b, 1);
        clear_mon();
        pulse_start(1);
        wait_done(1, 2000);
        @(negedge sysclk);
        check_frames_b("b_rerun");
        check_eq("b_rerun_vok", vok_b, 1);
        check_eq("b_rerun_err", err_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
